// File: rtl/apu_resp_pkg.sv
// Shared types and constants for the APU responder: op codes, latency classes
// and the return-record layout used by the dispatcher side.
package apu_resp_pkg;

  localparam int APU_DATA_W = 32;
  localparam int APU_TAG_W  = 6;
  localparam int APU_CNT_W  = 5;

  typedef enum logic [1:0] {
    APU_OP_ADD  = 2'd0,
    APU_OP_SUB  = 2'd1,
    APU_OP_MUL  = 2'd2,
    APU_OP_MAXU = 2'd3
  } apu_op_e;

  localparam logic [1:0] APU_LAT_SINGLE = 2'd1;
  localparam logic [1:0] APU_LAT_PIPE   = 2'd2;
  localparam logic [1:0] APU_LAT_MULTI  = 2'd3;

  typedef struct packed {
    logic                  valid;
    logic [APU_TAG_W-1:0]  tag;
    logic [APU_DATA_W-1:0] result;
  } apu_result_t;

  // Class 0 is not a real class; the dispatcher treats it as single-cycle.
  function automatic logic [1:0] apu_lat_class(input logic [1:0] lat);
    return (lat == 2'd0) ? APU_LAT_SINGLE : lat;
  endfunction

endpackage

// File: rtl/apu_resp_alu.sv
// Combinational integer datapath shared by all latency classes.
module apu_resp_alu
  import apu_resp_pkg::*;
#(
  parameter int WIDTH = APU_DATA_W
) (
  input  apu_op_e          op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      APU_OP_ADD:  result = operand_a + operand_b;
      APU_OP_SUB:  result = operand_a - operand_b;
      APU_OP_MUL:  result = operand_a * operand_b;
      APU_OP_MAXU: result = (operand_a > operand_b) ? operand_a : operand_b;
      default:     result = '0;
    endcase
  end

endmodule

// File: rtl/apu_resp_unit.sv
// APU responder: single-cycle, fixed-pipeline and iterative return paths
// merged onto one valid/ready result channel with fixed priority.
module apu_resp_unit
  import apu_resp_pkg::*;
#(
  parameter int WIDTH       = APU_DATA_W,
  parameter int TAG_W       = APU_TAG_W,
  parameter int PIPE_LAT    = 2,
  parameter int ITER_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             apu_slave_req_i,
  output logic             apu_slave_gnt_o,
  input  logic [1:0]       apu_slave_lat_i,
  input  logic [1:0]       apu_slave_op_i,
  input  logic [WIDTH-1:0] apu_slave_operand_a_i,
  input  logic [WIDTH-1:0] apu_slave_operand_b_i,
  input  logic [TAG_W-1:0] apu_slave_tag_i,
  output logic             apu_slave_valid_o,
  input  logic             apu_slave_ready_i,
  output logic [WIDTH-1:0] apu_slave_result_o,
  output logic [TAG_W-1:0] apu_slave_tag_o,
  output logic             busy_o
);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] result;
  } stage_t;

  stage_t                 stage_reg [PIPE_LAT];
  logic [PIPE_LAT-1:0]    stage_vld;
  logic                   iter_vld_reg;
  logic [APU_CNT_W-1:0]   iter_cnt_reg;
  logic [TAG_W-1:0]       iter_tag_reg;
  logic [WIDTH-1:0]       iter_res_reg;

  logic [1:0]             lat_class;
  logic [WIDTH-1:0]       alu_res;
  logic                   src_iter;
  logic                   src_tail;
  logic                   stall;
  logic                   pipe_adv;
  logic                   accept_ok;
  logic                   gnt_single;
  logic                   gnt_pipe;
  logic                   gnt_multi;
  stage_t                 ret;

  apu_resp_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op       (apu_op_e'(apu_slave_op_i)),
    .operand_a(apu_slave_operand_a_i),
    .operand_b(apu_slave_operand_b_i),
    .result   (alu_res)
  );

  for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage_vld
    assign stage_vld[gi] = stage_reg[gi].valid;
  end

  always_comb begin
    lat_class = apu_lat_class(apu_slave_lat_i);
    src_iter  = iter_vld_reg && (iter_cnt_reg == '0);
    src_tail  = stage_reg[PIPE_LAT-1].valid;
    stall     = (src_iter || src_tail) && !apu_slave_ready_i;
    // The tail may only move when it is empty or actually handed over.
    pipe_adv  = !src_tail || (!src_iter && apu_slave_ready_i);
    accept_ok = rst_ni && apu_slave_req_i && !stall;
    gnt_single = accept_ok && (lat_class == APU_LAT_SINGLE)
                 && !src_iter && !src_tail && apu_slave_ready_i;
    gnt_pipe   = accept_ok && (lat_class == APU_LAT_PIPE) && pipe_adv;
    gnt_multi  = accept_ok && (lat_class == APU_LAT_MULTI)
                 && (!iter_vld_reg || (src_iter && apu_slave_ready_i));
  end

  always_comb begin
    ret = '0;
    if (rst_ni) begin
      if (src_iter) begin
        ret = '{valid: 1'b1, tag: iter_tag_reg, result: iter_res_reg};
      end else if (src_tail) begin
        ret = stage_reg[PIPE_LAT-1];
      end else if (gnt_single) begin
        ret = '{valid: 1'b1, tag: apu_slave_tag_i, result: alu_res};
      end
    end
  end

  assign apu_slave_gnt_o    = gnt_single || gnt_pipe || gnt_multi;
  assign apu_slave_valid_o  = ret.valid;
  assign apu_slave_result_o = ret.result;
  assign apu_slave_tag_o    = ret.tag;
  assign busy_o             = (|stage_vld) || iter_vld_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        stage_reg[i] <= '0;
      end
      iter_vld_reg <= 1'b0;
      iter_cnt_reg <= '0;
      iter_tag_reg <= '0;
      iter_res_reg <= '0;
    end else begin
      if (pipe_adv) begin
        stage_reg[0] <= '{valid: gnt_pipe, tag: apu_slave_tag_i, result: alu_res};
        for (int i = 1; i < PIPE_LAT; i++) begin
          stage_reg[i] <= stage_reg[i-1];
        end
      end
      // A new iterative op may load in the same cycle the previous one retires.
      if (gnt_multi) begin
        iter_vld_reg <= 1'b1;
        iter_cnt_reg <= APU_CNT_W'(ITER_CYCLES - 1);
        iter_tag_reg <= apu_slave_tag_i;
        iter_res_reg <= alu_res;
      end else if (src_iter && apu_slave_ready_i) begin
        iter_vld_reg <= 1'b0;
      end else if (iter_vld_reg && (iter_cnt_reg != '0)) begin
        iter_cnt_reg <= iter_cnt_reg - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apu_resp_unit.sv
// Self-checking bench for apu_resp_unit: directed scenarios with literal
// expectations, then randomized traffic checked against a queue-based model.
module tb_apu_resp_unit;

  localparam int W  = 32;
  localparam int TW = 6;
  localparam int PL = 2;
  localparam int IC = 8;

  localparam logic [1:0] ADD  = 2'd0;
  localparam logic [1:0] SUB  = 2'd1;
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [1:0] MAXU = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n, req, gnt, valid, ready, busy;
  logic [1:0]    lat, op;
  logic [W-1:0]  a, b, res;
  logic [TW-1:0] tag, tag_out;

  always #5 clk = ~clk;

  apu_resp_unit #(
    .WIDTH(W), .TAG_W(TW), .PIPE_LAT(PL), .ITER_CYCLES(IC)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .apu_slave_req_i      (req),
    .apu_slave_gnt_o      (gnt),
    .apu_slave_lat_i      (lat),
    .apu_slave_op_i       (op),
    .apu_slave_operand_a_i(a),
    .apu_slave_operand_b_i(b),
    .apu_slave_tag_i      (tag),
    .apu_slave_valid_o    (valid),
    .apu_slave_ready_i    (ready),
    .apu_slave_result_o   (res),
    .apu_slave_tag_o      (tag_out),
    .busy_o               (busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: pipeline contents as a FIFO of entries with an age (cycles of
  // advancement since accept); the iterative unit as one record with a countdown.
  typedef struct {
    logic [TW-1:0] tag;
    logic [W-1:0]  res;
    int            age;
  } pent_t;

  pent_t         pq[$];
  bit            it_v = 0;
  int            it_cnt = 0;
  logic [TW-1:0] it_tag = '0;
  logic [W-1:0]  it_res = '0;
  bit            model_ok = 0;

  logic          o_gnt, o_valid, o_busy;
  logic [W-1:0]  o_res;
  logic [TW-1:0] o_tag;

  function automatic logic [W-1:0] ref_op(input logic [1:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    case (o)
      ADD:     return x + y;
      SUB:     return x - y;
      MUL:     return x * y;
      default: return (x > y) ? x : y;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rn, input bit rq, input logic [1:0] lt, input logic [1:0] opc,
                      input logic [W-1:0] x, input logic [W-1:0] y, input logic [TW-1:0] tg,
                      input bit rdy);
    bit            si, st, stl, adv, g, ev, eb;
    int            le;
    logic [W-1:0]  er;
    logic [TW-1:0] et;
    pent_t         e;
    @(negedge clk);
    rst_n = rn; req = rq; lat = lt; op = opc; a = x; b = y; tag = tg; ready = rdy;
    #1;
    o_gnt = gnt; o_valid = valid; o_res = res; o_tag = tag_out; o_busy = busy;

    le  = (lt == 2'd0) ? 1 : int'(lt);
    si  = it_v && (it_cnt == 0);
    st  = (pq.size() > 0) && (pq[0].age == PL);
    stl = (si || st) && !rdy;
    adv = !st || (!si && rdy);
    g   = 0;
    if (rn && rq && !stl) begin
      case (le)
        1:       g = !si && !st && rdy;
        2:       g = adv;
        default: g = !it_v || (si && rdy);
      endcase
    end
    ev = 0; er = '0; et = '0;
    if (rn) begin
      if (si) begin
        ev = 1; er = it_res; et = it_tag;
      end else if (st) begin
        ev = 1; er = pq[0].res; et = pq[0].tag;
      end else if (g && le == 1) begin
        ev = 1; er = ref_op(opc, x, y); et = tg;
      end
    end
    eb = (pq.size() > 0) || it_v;

    if (model_ok) begin
      chk("gnt", 32'(o_gnt), 32'(g));
      chk("valid", 32'(o_valid), 32'(ev));
      chk("result", o_res, er);
      chk("tag", 32'(o_tag), 32'(et));
      chk("busy", 32'(o_busy), 32'(eb));
    end
    $display("cyc t=%0t rst_n=%0b req=%0b lat=%0d op=%0d gnt=%0b valid=%0b res=%h tag=%0d busy=%0b",
             $time, rn, rq, lt, opc, o_gnt, o_valid, o_res, o_tag, o_busy);

    @(posedge clk);
    if (!rn) begin
      pq.delete();
      it_v = 0; it_cnt = 0;
      model_ok = 1;
    end else begin
      if (si && rdy) it_v = 0;
      else if (it_v && it_cnt > 0) it_cnt--;
      if (g && le == 3) begin
        it_v = 1; it_cnt = IC - 1; it_tag = tg; it_res = ref_op(opc, x, y);
      end
      if (adv) begin
        if (st && !si && rdy) void'(pq.pop_front());
        for (int i = 0; i < pq.size(); i++) pq[i].age = pq[i].age + 1;
        if (g && le == 2) begin
          e.tag = tg; e.res = ref_op(opc, x, y); e.age = 1;
          pq.push_back(e);
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 2'd0, ADD, '0, '0, '0, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (((pq.size() > 0) || it_v) && n < 60) begin
      idle();
      n++;
    end
    idle();
    chk("drain_busy", 32'(o_busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; lat = 2'd0; op = ADD; a = '0; b = '0; tag = '0; ready = 1'b1;

    // Reset held with a request pending
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'd1, ADD, 32'd5, 32'd7, 6'd3, 1'b1);
      chk("rst_gnt", 32'(o_gnt), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);
    end
    step(1'b1, 1'b1, 2'd1, ADD, 32'd5, 32'd7, 6'd3, 1'b1);
    chk("lat1_gnt", 32'(o_gnt), 32'd1);
    chk("lat1_valid", 32'(o_valid), 32'd1);
    chk("lat1_res", o_res, 32'd12);
    chk("lat1_tag", 32'(o_tag), 32'd3);
    chk("post_rst_busy", 32'(o_busy), 32'd0);

    // Pipelined back-to-back
    step(1'b1, 1'b1, 2'd2, SUB, 32'd10, 32'd3, 6'd4, 1'b1);
    chk("p_gnt0", 32'(o_gnt), 32'd1);
    step(1'b1, 1'b1, 2'd2, MUL, 32'd6, 32'd7, 6'd5, 1'b1);
    chk("p_gnt1", 32'(o_gnt), 32'd1);
    idle();
    chk("p_res4", o_res, 32'd7);
    chk("p_tag4", 32'(o_tag), 32'd4);
    idle();
    chk("p_res5", o_res, 32'd42);
    chk("p_tag5", 32'(o_tag), 32'd5);
    step(1'b1, 1'b1, 2'd2, SUB, 32'd0, 32'd1, 6'd6, 1'b1);
    idle();
    idle();
    chk("p_wrap", o_res, 32'hFFFF_FFFF);
    drain();

    // Iterative, second request held off until the first completes
    step(1'b1, 1'b1, 2'd3, MAXU, 32'h8000_0000, 32'd1, 6'd9, 1'b1);
    chk("it_gnt0", 32'(o_gnt), 32'd1);
    idle();
    for (int c = 2; c < 8; c++) begin
      step(1'b1, 1'b1, 2'd3, ADD, 32'd1, 32'd1, 6'd10, 1'b1);
      chk("it_gnt_blocked", 32'(o_gnt), 32'd0);
    end
    step(1'b1, 1'b1, 2'd3, ADD, 32'd1, 32'd1, 6'd10, 1'b1);
    chk("it_valid8", 32'(o_valid), 32'd1);
    chk("it_res8", o_res, 32'h8000_0000);
    chk("it_tag8", 32'(o_tag), 32'd9);
    chk("it_gnt8", 32'(o_gnt), 32'd1);
    drain();

    // Iterative done collides with pipeline tail
    step(1'b1, 1'b1, 2'd3, ADD, 32'd100, 32'd1, 6'd20, 1'b1);
    for (int c = 1; c < 6; c++) idle();
    step(1'b1, 1'b1, 2'd2, SUB, 32'd50, 32'd8, 6'd21, 1'b1);
    idle();
    step(1'b1, 1'b1, 2'd2, ADD, 32'd1, 32'd2, 6'd22, 1'b1);
    chk("col_gnt", 32'(o_gnt), 32'd0);
    chk("col_tag_iter", 32'(o_tag), 32'd20);
    chk("col_res_iter", o_res, 32'd101);
    step(1'b1, 1'b1, 2'd2, ADD, 32'd1, 32'd2, 6'd22, 1'b1);
    chk("col_tag_tail", 32'(o_tag), 32'd21);
    chk("col_res_tail", o_res, 32'd42);
    chk("col_gnt_next", 32'(o_gnt), 32'd1);
    drain();

    // Backpressure on the tail
    step(1'b1, 1'b1, 2'd2, ADD, 32'd3, 32'd4, 6'd30, 1'b1);
    idle();
    for (int c = 0; c < 4; c++) begin
      step(1'b1, 1'b1, 2'd2, ADD, 32'd9, 32'd9, 6'd31, 1'b0);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_res", o_res, 32'd7);
      chk("bp_tag", 32'(o_tag), 32'd30);
      chk("bp_gnt", 32'(o_gnt), 32'd0);
    end
    step(1'b1, 1'b1, 2'd2, ADD, 32'd9, 32'd9, 6'd31, 1'b1);
    chk("bp_release_tag", 32'(o_tag), 32'd30);
    chk("bp_release_gnt", 32'(o_gnt), 32'd1);
    drain();

    // Reset with work in flight
    step(1'b1, 1'b1, 2'd3, ADD, 32'd1, 32'd1, 6'd40, 1'b1);
    for (int c = 1; c < 4; c++) idle();
    step(1'b1, 1'b1, 2'd2, ADD, 32'd2, 32'd2, 6'd41, 1'b1);
    step(1'b0, 1'b0, 2'd0, ADD, '0, '0, '0, 1'b1);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    idle();
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    for (int c = 0; c < 12; c++) begin
      idle();
      chk("ghost", 32'(o_valid && (o_tag == 6'd40 || o_tag == 6'd41)), 32'd0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] ra, rb;
      ra = (($urandom_range(0, 3) == 0)) ? 32'hFFFF_FFFF - W'($urandom_range(0, 3)) : W'($urandom);
      rb = (($urandom_range(0, 3) == 0)) ? W'($urandom_range(0, 3)) : W'($urandom);
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), ra, rb,
           TW'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_resp_unit.md
Name: apu_resp_unit

Overview:
- APU-interconnect responder (slave end) for the core's APU dispatcher.
- Accepts requests on the req/gnt handshake and computes a small integer op.
- Returns each result with its 6-bit register tag on the valid/ready channel.
- Timing depends on the latency class: 1 = same cycle, 2 = fixed pipeline, 3 = iterative multicycle.
- Serves as the single-unit APU used in core-level regressions of the dispatcher.

Parameters:
- WIDTH, 32: operand/result width.
- TAG_W, 6: register-tag width; matches the dispatcher waddr.
- PIPE_LAT, 2: cycles from accept to valid for lat class 2; legal range 1..4.
- ITER_CYCLES, 8: cycles from accept to valid for lat class 3; legal range 2..31.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- apu_slave_req_i  in  1  request valid
- apu_slave_gnt_o  out  1  request accepted this cycle
- apu_slave_lat_i  in  2  latency class; 0 is treated as 1
- apu_slave_op_i  in  2  0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 MAXU
- apu_slave_operand_a_i  in  WIDTH  operand A
- apu_slave_operand_b_i  in  WIDTH  operand B
- apu_slave_tag_i  in  TAG_W  destination register tag
- apu_slave_valid_o  out  1  result valid
- apu_slave_ready_i  in  1  master ready to take the result
- apu_slave_result_o  out  WIDTH  result
- apu_slave_tag_o  out  TAG_W  tag of the returned result
- busy_o  out  1  any pipeline stage or the iterative unit is occupied

Behaviour:
- One clock, clk_i. Reset is synchronous and active-low (rst_ni sampled on the rising clk_i edge).
- Reset clears all stage valids, the iterative counter and busy. After reset: gnt_o=0 (no req), valid_o=0, result_o=0, tag_o=0, busy_o=0.
- Reset mid-operation discards all in-flight results; no valid is produced for them.
- Arithmetic: wrap-around modulo 2^WIDTH. MAXU is unsigned. Result is computed combinationally from operands at accept; ops carry no further state.
- Return sources, in fixed priority:
  - (1) iterative done: counter reached 0 with ITER valid.
  - (2) pipeline tail: stage PIPE_LAT-1 valid.
  - (3) same-cycle lat-1 request.
- valid_o = any source present. result_o/tag_o come from the highest-priority present source; they are 0 when valid_o=0.
- Lat 1: valid_o, result_o and tag_o are combinational in the same cycle as req & gnt; zero-cycle latency.
  - gnt=0 if source 1 or 2 is present, or if ready_i=0.
- Lat 2: inserted into stage 0; valid_o at tail exactly PIPE_LAT cycles after accept when unstalled.
  - Pipeline advances only when the tail is empty, or the tail is selected and ready_i=1.
  - Otherwise all stages freeze, including when source 1 wins over the tail.
  - gnt for lat 2 = pipeline advances this cycle.
- Lat 3: one outstanding, non-pipelined. Counter loads ITER_CYCLES-1 at accept and decrements each cycle to 0, then holds in done.
  - Done remains valid until selected with ready_i=1.
  - gnt for lat 3 = iterative unit idle, or completing with ready_i=1 this cycle.
- Backpressure: if ready_i=0 while valid_o=1, result_o/tag_o hold stable, no return source is consumed, and gnt_o=0.
- Back-to-back: a lat-2 accept is allowed every cycle while the pipe advances, giving full throughput.
- gnt_o is 0 whenever req_i=0.
- busy_o = |stage valids | iter valid; registered-state only.
- Results are in order per class. Cross-class ordering relies on the dispatcher's latency-type stall rule; the responder does not reorder.

Decomposition:
- Shared package apu_resp_pkg: op enum (APU_OP_ADD/SUB/MUL/MAXU), lat class constants (APU_LAT_SINGLE=1, APU_LAT_PIPE=2, APU_LAT_MULTI=3), result struct {valid, tag, result}.
- One sub-module apu_resp_alu: combinational op decode and compute, shared by all three classes.
- Pipeline and iterative control stay in the top module.

Test Plan:
- Reset held 3 cycles with req_i=1 -> gnt_o=0, valid_o=0, busy_o=0. Release -> ADD 5+7 lat1 tag 3 gives same-cycle gnt=1, valid=1, result=12, tag=3.
- Lat 2 (PIPE_LAT=2) back-to-back SUB 10-3 tag 4, then MUL 6*7 tag 5 at cycles 0,1 -> valid at cycles 2,3 with 7/tag4, 42/tag5. SUB 0-1 -> 0xFFFFFFFF.
- Lat 3 (ITER_CYCLES=8) MAXU 0x80000000,1 tag 9 at cycle 0 -> valid at cycle 8, result 0x80000000. A second lat-3 req at cycle 2 -> gnt=0 until cycle 8, then granted that cycle.
- Collision: lat3 done and pipe tail valid in the same cycle -> iterative result returned first, pipe frozen, tail returned next cycle, lat2 req gnt=0 in the collision cycle.
- ready_i=0 for 4 cycles with tail valid -> valid_o held, result/tag stable, gnt_o=0. ready_i=1 -> one consumption, pipe resumes.
- Reset asserted while a lat3 op is at count 3 and a lat2 op is in stage 0 -> next cycle busy_o=0, and no valid_o is ever produced for either tag.
